uart_rx_os: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx_os.sv | 135 +++++++++++++
 tb/tb_uart_rx_os.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, width helper and default oversample ratio.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } state_t;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  // Bits needed to hold values 0..value-1 (minimum 0).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned r = 0; r < 32; r++) begin
      if (value > (32'd1 << r)) result = r + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, false-start rejection, framing-error
// detection, pulse and toggle delivery strobes.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 8,
  parameter logic        START_BIT  = 1'b0,
  parameter logic        LSB_TO_MSB = 1'b1,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx_pin,
  output logic [BIT_WIDTH-1:0] rx_reg,
  output logic                 valid,
  output logic                 valid_tgl,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned TICK_W    = clog2(OVERSAMPLE);
  localparam int unsigned BIT_CNT_W = clog2(BIT_WIDTH + 1);
  localparam logic [TICK_W-1:0]    TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(BIT_WIDTH - 1);
  localparam logic                 IDLE_LVL  = ~START_BIT;

  logic syn;

  state_t                 state, state_next;
  logic [TICK_W-1:0]      tick_cnt, tick_cnt_next;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_next;
  logic [BIT_WIDTH-1:0]   shift, shift_next;
  logic [BIT_WIDTH-1:0]   rx_reg_next;
  logic                   valid_next, valid_tgl_next, frame_err_next, busy_next;

  sync_2ff #(.RESET_VAL(IDLE_LVL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_pin),
    .q   (syn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_reg    <= '0;
      valid     <= 1'b0;
      valid_tgl <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift     <= shift_next;
      rx_reg    <= rx_reg_next;
      valid     <= valid_next;
      valid_tgl <= valid_tgl_next;
      frame_err <= frame_err_next;
      busy      <= busy_next;
    end
  end

  // Frame FSM; every decision is taken only on oversample ticks.
  always_comb begin
    state_next     = state;
    tick_cnt_next  = tick_cnt;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    rx_reg_next    = rx_reg;
    valid_next     = 1'b0;
    valid_tgl_next = valid_tgl;
    frame_err_next = frame_err;

    if (tick) begin
      case (state)
        IDLE: begin
          if (syn == START_BIT) begin
            state_next    = START;
            tick_cnt_next = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            state_next    = (syn == START_BIT) ? DATA : IDLE;
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            shift_next    = LSB_TO_MSB ? {syn, shift[BIT_WIDTH-1:1]}
                                       : {shift[BIT_WIDTH-2:0], syn};
            bit_cnt_next  = bit_cnt + BIT_CNT_W'(1);
            tick_cnt_next = '0;
            if (bit_cnt == BIT_LAST) state_next = STOP;
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_next = '0;
            if (syn == IDLE_LVL) begin
              rx_reg_next    = shift;
              valid_next     = 1'b1;
              valid_tgl_next = ~valid_tgl;
              frame_err_next = 1'b0;
              state_next     = IDLE;
            end else begin
              frame_err_next = 1'b1;
              state_next     = BRK_WAIT;
            end
          end else begin
            tick_cnt_next = tick_cnt + TICK_W'(1);
          end
        end
        BRK_WAIT: begin
          if (syn == IDLE_LVL) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed frame table, corner-case sequences and random frames
// checked against a frame-level reference model.
module tb_uart_rx_os;

  localparam int unsigned BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_reg, rx_reg_m;
  logic       valid, valid_tgl, frame_err, busy;
  logic       valid_m, valid_tgl_m, frame_err_m, busy_m;

  uart_rx_os #(.BIT_WIDTH(8), .START_BIT(1'b0), .LSB_TO_MSB(1'b1), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .tick(tick), .rx_pin(rx_pin),
    .rx_reg(rx_reg), .valid(valid), .valid_tgl(valid_tgl), .frame_err(frame_err), .busy(busy)
  );

  uart_rx_os #(.BIT_WIDTH(8), .START_BIT(1'b0), .LSB_TO_MSB(1'b0), .OVERSAMPLE(16)) dut_m (
    .clk(clk), .rst(rst), .tick(tick), .rx_pin(rx_pin),
    .rx_reg(rx_reg_m), .valid(valid_m), .valid_tgl(valid_tgl_m), .frame_err(frame_err_m),
    .busy(busy_m)
  );

  initial forever #5 clk = ~clk;

  int unsigned ph = 0;
  initial begin
    forever begin
      @(negedge clk);
      tick = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  // Output monitor: counts strobes and frame_err rises, stamps valid cycles.
  int unsigned cyc = 0, n_val = 0, n_val_m = 0, n_ferr = 0, n_vbusy = 0;
  int unsigned last_v = 0, prev_v = 0;
  logic ferr_q = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid) begin
        n_val++;
        prev_v = last_v;
        last_v = cyc;
        if (busy) n_vbusy++;
      end
      if (valid_m) n_val_m++;
      if (frame_err && !ferr_q) n_ferr++;
      ferr_q = frame_err;
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Reference model state at frame level.
  logic [7:0] m_reg = 8'h00;
  logic       m_tgl = 1'b0;
  logic       m_ferr = 1'b0;
  int unsigned v0, vm0, f0;

  task automatic snap();
    v0 = n_val; vm0 = n_val_m; f0 = n_ferr;
  endtask

  task automatic drive_bits(input logic lvl, input int unsigned clks);
    rx_pin = lvl;
    repeat (clks) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] d, input bit ok, input int unsigned hold,
                             input int unsigned gap);
    drive_bits(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive_bits(d[i], BIT_CLK);
    drive_bits(ok ? 1'b1 : 1'b0, BIT_CLK);
    drive_bits(1'b0, hold * BIT_CLK);
    drive_bits(1'b1, gap * BIT_CLK);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit ok,
                           input int unsigned hold, input int unsigned gap,
                           input bit exp_v, input logic [7:0] exp_reg, input logic exp_ferr);
    int unsigned rise;
    snap();
    drive_frame(d, ok, hold, gap);
    rise = (exp_ferr && !m_ferr) ? 1 : 0;
    if (exp_v) m_tgl = ~m_tgl;
    m_reg = exp_reg;
    m_ferr = exp_ferr;
    chk({tag, ".valid_cnt"}, 32'(n_val - v0), 32'(exp_v));
    chk({tag, ".valid_cnt_m"}, 32'(n_val_m - vm0), 32'(exp_v));
    chk({tag, ".rx_reg"}, 32'(rx_reg), 32'(m_reg));
    chk({tag, ".rx_reg_m"}, 32'(rx_reg_m), 32'(rev8(m_reg)));
    chk({tag, ".valid_tgl"}, 32'(valid_tgl), 32'(m_tgl));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, ".ferr_rises"}, 32'(n_ferr - f0), 32'(rise));
    if (gap > 0) chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          ok;
    int unsigned hold;
    int unsigned gap;
    bit          exp_valid;
    logic [7:0]  exp_reg;
    logic        exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] rd;
    bit         rok;
    int unsigned diff;

    vecs[0] = '{8'hA5, 1'b1, 0,  2, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 20, 2, 1'b0, 8'hA5, 1'b1};
    vecs[2] = '{8'h3C, 1'b1, 0,  2, 1'b1, 8'h3C, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 0,  0, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 0,  2, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 0,  1, 1'b1, 8'h81, 1'b0};
    vecs[6] = '{8'h7E, 1'b0, 0,  1, 1'b0, 8'h81, 1'b1};
    vecs[7] = '{8'hC3, 1'b0, 0,  2, 1'b0, 8'h81, 1'b1};

    rst = 1'b1;
    rx_pin = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset.rx_reg", 32'(rx_reg), 32'd0);
    chk("reset.rx_reg_m", 32'(rx_reg_m), 32'd0);
    chk("reset.valid", 32'(valid), 32'd0);
    chk("reset.valid_tgl", 32'(valid_tgl), 32'd0);
    chk("reset.frame_err", 32'(frame_err), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    drive_bits(1'b1, 2 * BIT_CLK);

    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].ok, vecs[i].hold, vecs[i].gap,
                vecs[i].exp_valid, vecs[i].exp_reg, vecs[i].exp_ferr);
    end

    // Back-to-back frames without an idle gap.
    snap();
    drive_frame(8'h00, 1'b1, 0, 0);
    drive_frame(8'hFF, 1'b1, 0, 2);
    diff = last_v - prev_v;
    chk("b2b.valid_cnt", 32'(n_val - v0), 32'd2);
    chk("b2b.spacing_ok", 32'(diff >= 632 && diff <= 648), 32'd1);
    chk("b2b.valid_tgl", 32'(valid_tgl), 32'(m_tgl));
    chk("b2b.rx_reg", 32'(rx_reg), 32'hFF);
    chk("b2b.frame_err", 32'(frame_err), 32'd0);
    m_reg = 8'hFF;
    m_ferr = 1'b0;

    // Start glitch of 5 ticks must be rejected at the mid-start check.
    snap();
    drive_bits(1'b0, 20);
    chk("glitch.busy_hi", 32'(busy), 32'd1);
    drive_bits(1'b1, 40);
    chk("glitch.busy_lo", 32'(busy), 32'd0);
    chk("glitch.valid_cnt", 32'(n_val - v0), 32'd0);
    chk("glitch.rx_reg", 32'(rx_reg), 32'(m_reg));
    chk("glitch.frame_err", 32'(frame_err), 32'd0);
    drive_bits(1'b1, BIT_CLK);

    // Reset in the middle of data bit 4 of 0xF0; tail of the frame is idle-level.
    snap();
    drive_bits(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_bits(1'b0, BIT_CLK);
    drive_bits(1'b1, 32);
    rst = 1'b1;
    drive_bits(1'b1, 3);
    chk("rstmid.rx_reg", 32'(rx_reg), 32'd0);
    chk("rstmid.rx_reg_m", 32'(rx_reg_m), 32'd0);
    chk("rstmid.valid_tgl", 32'(valid_tgl), 32'd0);
    chk("rstmid.frame_err", 32'(frame_err), 32'd0);
    chk("rstmid.busy", 32'(busy), 32'd0);
    rst = 1'b0;
    m_reg = 8'h00;
    m_tgl = 1'b0;
    m_ferr = 1'b0;
    drive_bits(1'b1, 29 + 3 * BIT_CLK + BIT_CLK + 2 * BIT_CLK);
    chk("rstmid.valid_cnt", 32'(n_val - v0), 32'd0);
    run_frame("after_rst", 8'h5A, 1'b1, 0, 2, 1'b1, 8'h5A, 1'b0);

    // Random frames against the frame-level model.
    for (int i = 0; i < 12; i++) begin
      rd = 8'($urandom);
      rok = ($urandom_range(3) != 0);
      run_frame($sformatf("rnd%0d", i), rd, rok,
                rok ? 0 : $urandom_range(3),
                rok ? $urandom_range(2) : $urandom_range(2, 1),
                rok, rok ? rd : m_reg, rok ? 1'b0 : 1'b1);
    end
    drive_bits(1'b1, 2 * BIT_CLK);

    chk("valid_while_busy", 32'(n_vbusy), 32'd0);
    chk("valid_count_match", 32'(n_val), 32'(n_val_m));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
